hdmi_pixel_align: RTL

HDMI_PIXEL_ALIGN -- requirements
Module: hdmi_pixel_align

---
 rtl/hdmi_pixel_align_if.sv | 41 ++++
 rtl/hdmi_pixel_align.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hdmi_pixel_align_if.sv
// hdmi_pixel_align_if
// Bundles the timing-generator, frame-buffer read and pixel-output signals of
// hdmi_pixel_align. Clock and reset stay plain ports on the module.
//   I_vs/I_hs/I_de   timing-generator syncs and active video (positive polarity)
//   I_vin_den        frame-buffer read data valid
//   I_vin_data[15:0] RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   I_div_en         centre divider enable, sampled at frame start
//   I_flag_clr       clears the sticky underflow flag
//   O_vs/O_hs/O_de   aligned syncs and active video
//   O_r/O_g/O_b      RGB888 pixel
//   O_underflow_cnt  underflow count of the last completed frame
//   O_underflow_flag sticky underflow indicator
// modport master: the source/sink side (timing generator, frame buffer, display).
// modport slave:  the aligner itself.
interface hdmi_pixel_align_if;
  logic        I_vs;
  logic        I_hs;
  logic        I_de;
  logic        I_vin_den;
  logic [15:0] I_vin_data;
  logic        I_div_en;
  logic        I_flag_clr;
  logic        O_vs;
  logic        O_hs;
  logic        O_de;
  logic [7:0]  O_r;
  logic [7:0]  O_g;
  logic [7:0]  O_b;
  logic [15:0] O_underflow_cnt;
  logic        O_underflow_flag;

  modport master (
    output I_vs, I_hs, I_de, I_vin_den, I_vin_data, I_div_en, I_flag_clr,
    input  O_vs, O_hs, O_de, O_r, O_g, O_b, O_underflow_cnt, O_underflow_flag
  );

  modport slave (
    input  I_vs, I_hs, I_de, I_vin_den, I_vin_data, I_div_en, I_flag_clr,
    output O_vs, O_hs, O_de, O_r, O_g, O_b, O_underflow_cnt, O_underflow_flag
  );
endinterface

// File: rtl/hdmi_pixel_align.sv
// hdmi_pixel_align
// Re-aligns the timing-generator syncs with pixel data returned by a frame
// buffer read port that answers RD_LAT cycles after I_de. Syncs are delayed
// RD_LAT+1 cycles; the pixel is sampled when the RD_LAT-delayed de (de_d) is
// high and registered alongside the final sync stage. RGB565 is widened to
// RGB888 by MSB replication. A missing read (de_d high, I_vin_den low) emits
// FILL_COLOR and is counted per frame. An optional centre divider of DIV_W
// columns overrides the pixel with DIV_COLOR.
// Ports:
//   I_pxl_clk  pixel clock, sole clock
//   I_rst      asynchronous active-high reset
//   vid        hdmi_pixel_align_if.slave (video in, frame-buffer data, video out)
// Output video stays blanked (O_de=0, RGB=0) until the first delayed vsync
// rising edge after reset; syncs pass through throughout.
module hdmi_pixel_align #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned H_RES      = 1280,
  parameter int unsigned DIV_W      = 4,
  parameter logic [23:0] DIV_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic               I_pxl_clk,
  input  logic               I_rst,
  hdmi_pixel_align_if.slave  vid
);

  localparam int unsigned DIV_LO = H_RES / 2 - DIV_W / 2;
  localparam int unsigned DIV_HI = H_RES / 2 + DIV_W / 2 - 1;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_t;

  state_t             state;

  // Sync delay lines; bit RD_LAT-1 is the RD_LAT-delayed tap.
  logic [RD_LAT-1:0]  vs_sr;
  logic [RD_LAT-1:0]  hs_sr;
  logic [RD_LAT-1:0]  de_sr;

  logic               vs_q;
  logic               hs_q;
  logic               de_q;
  logic               de_prev;
  logic [10:0]        col;
  logic [15:0]        run_cnt;
  logic [15:0]        cnt_q;
  logic               flag_q;
  logic               div_lat;
  logic [7:0]         r_q;
  logic [7:0]         g_q;
  logic [7:0]         b_q;

  logic               vs_d;
  logic               hs_d;
  logic               de_d;
  logic               vs_rise;
  logic               de_rise;
  logic               underflow;
  logic               in_div;
  logic [10:0]        col_cur;
  logic [23:0]        pix;

  always_comb begin
    vs_d      = vs_sr[RD_LAT-1];
    hs_d      = hs_sr[RD_LAT-1];
    de_d      = de_sr[RD_LAT-1];
    // vs_q holds the previous vs_d, so it doubles as the edge detector.
    vs_rise   = vs_d & ~vs_q;
    de_rise   = de_d & ~de_prev;
    // Column of the pixel being sampled this cycle: 0 on the first pixel of a line.
    col_cur   = de_rise ? '0 : col;
    in_div    = div_lat && (col_cur >= 11'(DIV_LO)) && (col_cur <= 11'(DIV_HI));
    underflow = (state == ACTIVE) && de_d && !vid.I_vin_den;
    pix       = FILL_COLOR;
    if (in_div) begin
      pix = DIV_COLOR;
    end else if (vid.I_vin_den) begin
      pix = {vid.I_vin_data[15:11], vid.I_vin_data[15:13],
             vid.I_vin_data[10:5],  vid.I_vin_data[10:9],
             vid.I_vin_data[4:0],   vid.I_vin_data[4:2]};
    end
  end

  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      state   <= WAIT_VS;
      vs_sr   <= '0;
      hs_sr   <= '0;
      de_sr   <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      de_prev <= 1'b0;
      col     <= '0;
      run_cnt <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      div_lat <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      vs_sr[0] <= vid.I_vs;
      hs_sr[0] <= vid.I_hs;
      de_sr[0] <= vid.I_de;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vs_sr[i] <= vs_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        de_sr[i] <= de_sr[i-1];
      end

      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_prev <= de_d;

      if (de_d) begin
        col <= col_cur + 11'd1;
      end

      case (state)
        WAIT_VS: begin
          de_q <= 1'b0;
          r_q  <= '0;
          g_q  <= '0;
          b_q  <= '0;
          if (vs_rise) begin
            state <= ACTIVE;
            cnt_q <= '0;
          end
        end
        ACTIVE: begin
          de_q <= de_d;
          if (de_d) begin
            {r_q, g_q, b_q} <= pix;
          end else begin
            {r_q, g_q, b_q} <= '0;
          end
          if (vs_rise) begin
            cnt_q <= run_cnt;
          end
        end
        default: state <= WAIT_VS;
      endcase

      // A frame boundary coinciding with an underflow starts the new frame at 1.
      if (vs_rise) begin
        run_cnt <= underflow ? 16'd1 : '0;
        div_lat <= vid.I_div_en;
      end else if (underflow && (run_cnt != '1)) begin
        run_cnt <= run_cnt + 16'd1;
      end

      if (underflow) begin
        flag_q <= 1'b1;
      end else if (vid.I_flag_clr) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign vid.O_vs             = vs_q;
  assign vid.O_hs             = hs_q;
  assign vid.O_de             = de_q;
  assign vid.O_r              = r_q;
  assign vid.O_g              = g_q;
  assign vid.O_b              = b_q;
  assign vid.O_underflow_cnt  = cnt_q;
  assign vid.O_underflow_flag = flag_q;

endmodule
